viterbi_pmu: RTL and testbench



---
 rtl/viterbi_pkg.sv | 40 ++++
 rtl/viterbi_acs_unit.sv | 32 +++
 rtl/viterbi_pmu.sv | 196 +++++++++++++++++++
 tb/tb_viterbi_pmu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the rate-1/2 Viterbi path-metric unit.
// Pure combinational functions; no state, no latency of their own.
// No flow control here. SOFT_DEC_EN adds the soft-decision branch metric.
package viterbi_pkg;

  localparam int K_DFLT  = 4;
  localparam int MW_DFLT = 8;
  localparam int NS      = 2 ** (K_DFLT - 1);

  // Path metric at the default width
  typedef logic [MW_DFLT-1:0] metric_t;

  // Encoder outputs {c0,c1} when input bit b leaves the encoder in predecessor state 'state'.
  // The encoder register is {b, state}, newest bit at the MSB.
  function automatic logic [1:0] code_bits(input int unsigned state, input logic b,
                                           input int unsigned k, input int unsigned g0,
                                           input int unsigned g1);
    logic [31:0] r;
    r = ({31'd0, b} << (k - 32'd1)) | state;
    return {^(r & g0), ^(r & g1)};
  endfunction

  // Hamming distance between two 2-bit symbols, 0..2
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

`ifdef SOFT_DEC_EN
  // Soft distance: each received value is a confidence that the bit is 1
  function automatic int unsigned soft_bm(input logic [1:0] c, input int unsigned r0,
                                          input int unsigned r1, input int unsigned sw);
    int unsigned mx;
    mx = (32'd1 << sw) - 32'd1;
    return (c[1] ? mx - r0 : r0) + (c[0] ? mx - r1 : r1);
  endfunction
`endif

endpackage

// File: rtl/viterbi_acs_unit.sv
// Compare-select for one trellis state: picks the surviving predecessor.
// Purely combinational, zero latency.
// No flow control; the parent decides when results are registered.
module viterbi_acs_unit #(
  parameter int MW = 8
) (
  input  logic [MW-1:0] cand0_i,
  input  logic          vld0_i,
  input  logic [MW-1:0] cand1_i,
  input  logic          vld1_i,
  output logic [MW-1:0] met_o,
  output logic          dec_o,
  output logic          vld_o
);

  // Lower candidate wins, a tie keeps predecessor 0; an unreachable state reports 0
  always_comb begin
    dec_o = 1'b0;
    met_o = '0;
    vld_o = vld0_i | vld1_i;
    if (vld0_i && vld1_i) begin
      dec_o = (cand1_i < cand0_i);
      met_o = dec_o ? cand1_i : cand0_i;
    end else if (vld1_i) begin
      dec_o = 1'b1;
      met_o = cand1_i;
    end else if (vld0_i) begin
      met_o = cand0_i;
    end
  end

endmodule

// File: rtl/viterbi_pmu.sv
// Path-metric unit: branch metrics, ACS per state, saturating/normalised metrics, best state.
// A symbol accepted at an edge produces its decision vector at that same edge (one register stage).
// in_ready = !out_valid | out_ready; the output register holds while stalled. Macro: SOFT_DEC_EN.
module viterbi_pmu
  import viterbi_pkg::*;
#(
  parameter int             K  = K_DFLT,
  parameter logic [K-1:0]   G0 = K'(4'b1011),
  parameter logic [K-1:0]   G1 = K'(4'b1111),
  parameter int             MW = MW_DFLT,
  parameter int             SW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  frame_start,
`ifdef SOFT_DEC_EN
  input  logic [2*SW-1:0]       d_in,
`else
  input  logic [1:0]            d_in,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**(K-1)-1:0]   dec_vec,
  output logic [K-2:0]          best_state,
  output logic [MW-1:0]         best_metric
);

  localparam int                N_ST     = 2 ** (K - 1);
  localparam int                HALF     = N_ST / 2;
  localparam int                DW       = $bits(d_in);
  localparam logic [MW-1:0]     M_MAX    = '1;
  localparam logic [N_ST-1:0]   VLD_INIT = {{(N_ST-1){1'b0}}, 1'b1};

  if (K < 3 || MW < 2 || MW > 30 || SW < 1) begin : g_bad_param
    $error("viterbi_pmu: unsupported parameter set");
  end

  // Metric registers and their reachability flags
  logic [MW-1:0]   met_q [N_ST];
  logic [N_ST-1:0] vld_q;

  // Output registers
  logic            out_valid_q, out_valid_d;
  logic [N_ST-1:0] dec_vec_q;
  logic [K-2:0]    best_state_q, best_state_d;
  logic [MW-1:0]   best_metric_q, best_metric_d;

  // Combinational datapath
  logic            accept;
  logic [MW-1:0]   src_met [N_ST];
  logic [N_ST-1:0] src_vld;
  logic [MW-1:0]   acs_met [N_ST];
  logic [N_ST-1:0] acs_vld;
  logic [N_ST-1:0] acs_dec;
  logic [MW-1:0]   nrm_met [N_ST];
  logic            norm_en;
  logic            found;

  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] m, input int unsigned bm);
    int unsigned sum;
    sum = {{(32-MW){1'b0}}, m} + bm;
    if (sum > {{(32-MW){1'b0}}, M_MAX}) begin
      return M_MAX;
    end
    return sum[MW-1:0];
  endfunction

  function automatic int unsigned branch_metric(input logic [1:0] c, input logic [DW-1:0] d);
`ifdef SOFT_DEC_EN
    return soft_bm(c, 32'(d[DW-1:SW]), 32'(d[SW-1:0]), SW);
`else
    return {30'd0, hamming2(c, d)};
`endif
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A frame restart runs this symbol's ACS from the reset metrics instead of the stored ones
  always_comb begin
    for (int s = 0; s < N_ST; s++) begin
      src_met[s] = frame_start ? '0 : met_q[s];
    end
    src_vld = frame_start ? VLD_INIT : vld_q;
  end

  for (genvar ns = 0; ns < N_ST; ns++) begin : g_state
    // Predecessors differ only in the bit shifted out; the new input bit is the state MSB
    localparam int         P0   = (2 * ns) % N_ST;
    localparam int         P1   = P0 + 1;
    localparam logic       NB   = (ns >= HALF);
    localparam logic [1:0] C_P0 = code_bits(P0, NB, K, 32'(G0), 32'(G1));
    localparam logic [1:0] C_P1 = code_bits(P1, NB, K, 32'(G0), 32'(G1));

    logic [MW-1:0] cand0;
    logic [MW-1:0] cand1;

    // Extend both predecessor paths by their branch metric, clamped at full scale
    always_comb begin
      cand0 = sat_add(src_met[P0], branch_metric(C_P0, d_in));
      cand1 = sat_add(src_met[P1], branch_metric(C_P1, d_in));
    end

    viterbi_acs_unit #(
      .MW(MW)
    ) u_acs (
      .cand0_i (cand0),
      .vld0_i  (src_vld[P0]),
      .cand1_i (cand1),
      .vld1_i  (src_vld[P1]),
      .met_o   (acs_met[ns]),
      .dec_o   (acs_dec[ns]),
      .vld_o   (acs_vld[ns])
    );
  end

  // Once every live metric has its MSB set, drop that bit everywhere; differences are kept
  always_comb begin
    norm_en = 1'b1;
    for (int s = 0; s < N_ST; s++) begin
      if (acs_vld[s] && !acs_met[s][MW-1]) begin
        norm_en = 1'b0;
      end
    end
    for (int s = 0; s < N_ST; s++) begin
      nrm_met[s] = acs_met[s];
      if (norm_en) begin
        nrm_met[s][MW-1] = 1'b0;
      end
    end
  end

  // Smallest live metric; strict compare keeps the lowest index on ties
  always_comb begin
    found         = 1'b0;
    best_state_d  = '0;
    best_metric_d = '0;
    for (int s = 0; s < N_ST; s++) begin
      if (acs_vld[s] && (!found || nrm_met[s] < best_metric_d)) begin
        found         = 1'b1;
        best_metric_d = nrm_met[s];
        best_state_d  = (K-1)'(s);
      end
    end
  end

  // Output valid sets on acceptance and clears only when the consumer takes it
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Metrics advance only on an accepted symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_ST; s++) begin
        met_q[s] <= '0;
      end
      vld_q <= VLD_INIT;
    end else if (accept) begin
      for (int s = 0; s < N_ST; s++) begin
        met_q[s] <= nrm_met[s];
      end
      vld_q <= acs_vld;
    end
  end

  // Decision vector and best-state report, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      dec_vec_q     <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        dec_vec_q     <= acs_dec;
        best_state_q  <= best_state_d;
        best_metric_q <= best_metric_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign dec_vec     = dec_vec_q;
  assign best_state  = best_state_q;
  assign best_metric = best_metric_q;

endmodule

// File: tb/tb_viterbi_pmu.sv
// Randomised scoreboard bench for viterbi_pmu (K=4, G=1011/1111, MW=4 to stress normalisation).
// Driver pushes a reference-model expectation per accepted symbol; a monitor checks presented outputs.
// Reference model walks the trellis forward from every live state using the encoder definition.
module tb_viterbi_pmu;

  localparam int MMAX  = 15;
  localparam int MHALF = 8;
  localparam int G0I   = 'b1011;
  localparam int G1I   = 'b1111;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, frame_start, out_valid, out_ready;
  logic [1:0] d_in;
  logic [7:0] dec_vec;
  logic [2:0] best_state;
  logic [3:0] best_metric;

  always #5 clk = ~clk;

  viterbi_pmu #(.MW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .d_in        (d_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dec_vec     (dec_vec),
    .best_state  (best_state),
    .best_metric (best_metric)
  );

  typedef struct {
    logic [7:0] dec;
    int         bs;
    int         bm;
    bit         enc_chk;
    int         enc_s;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_norm = 0;
  int   m[8];
  bit   v[8];
  bit   exp_ov = 1'b0;
  bit   armed = 1'b0;
  bit   after_rst = 1'b0;
  bit   enc_chk_now = 1'b0;
  int   enc_s_now = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit parity(input int x);
    return ^x;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m[s] = 0;
      v[s] = 1'b0;
    end
    v[0] = 1'b1;
  endtask

  // One trellis step: every live state emits two branches; each next state keeps its cheapest
  // arrival, preferring the even predecessor on equal cost.
  task automatic model_step(input bit fs, input logic [1:0] d, output exp_t e);
    int nm[8];
    bit nv[8];
    logic [7:0] dv;
    bit all_hi;
    int bestm;
    if (fs) model_reset();
    dv = 8'h00;
    for (int s = 0; s < 8; s++) begin
      nm[s] = 0;
      nv[s] = 1'b0;
    end
    for (int p = 0; p < 8; p++) begin
      if (v[p]) begin
        for (int b = 0; b < 2; b++) begin
          int ns, r, bm, cand;
          ns   = b * 4 + p / 2;
          r    = b * 8 + p;
          bm   = int'(parity(r & G0I) != d[1]) + int'(parity(r & G1I) != d[0]);
          cand = m[p] + bm;
          if (cand > MMAX) cand = MMAX;
          if (!nv[ns] || cand < nm[ns] || (cand == nm[ns] && (p % 2) == 0)) begin
            nm[ns] = cand;
            nv[ns] = 1'b1;
            dv[ns] = ((p % 2) == 1);
          end
        end
      end
    end
    all_hi = 1'b1;
    for (int s = 0; s < 8; s++) if (nv[s] && nm[s] < MHALF) all_hi = 1'b0;
    if (all_hi) begin
      n_norm++;
      for (int s = 0; s < 8; s++) if (nv[s]) nm[s] = nm[s] - MHALF;
    end
    bestm = -1;
    e.bs = 0;
    e.bm = 0;
    for (int s = 0; s < 8; s++) begin
      if (nv[s] && (bestm < 0 || nm[s] < bestm)) begin
        bestm = nm[s];
        e.bs  = s;
        e.bm  = nm[s];
      end
    end
    e.dec = dv;
    e.enc_chk = 1'b0;
    e.enc_s = 0;
    for (int s = 0; s < 8; s++) begin
      m[s] = nm[s];
      v[s] = nv[s];
    end
  endtask

  // One clock of stimulus; inputs change just after the rising edge
  task automatic step(input bit vi, input bit fs, input logic [1:0] d, input bit ordy, input bit r);
    bit acc;
    exp_t e;
    in_valid = vi;
    frame_start = fs;
    d_in = d;
    out_ready = ordy;
    rst = r;
    @(negedge clk);
    if (armed) begin
      chk("out_valid", int'(out_valid), int'(exp_ov));
      chk("in_ready", int'(in_ready), int'(!exp_ov || ordy));
      if (after_rst) begin
        chk("rst_dec_vec", int'(dec_vec), 0);
        chk("rst_best_state", int'(best_state), 0);
        chk("rst_best_metric", int'(best_metric), 0);
      end
    end
    acc = vi && (!exp_ov || ordy) && !r;
    if (r) begin
      model_reset();
      exp_ov = 1'b0;
    end else if (acc) begin
      model_step(fs, d, e);
      e.enc_chk = enc_chk_now;
      e.enc_s = enc_s_now;
      sb.push_back(e);
      exp_ov = 1'b1;
    end else if (ordy) begin
      exp_ov = 1'b0;
    end
    after_rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      armed = 1'b1;
    end
  endtask

  // Monitor: compare whatever is presented against the oldest expectation; retire on transfer
  always @(negedge clk) begin
    if (armed && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: dec_vec=%0h with no expectation queued", dec_vec);
      end else begin
        chk("dec_vec", int'(dec_vec), int'(sb[0].dec));
        chk("best_state", int'(best_state), sb[0].bs);
        chk("best_metric", int'(best_metric), sb[0].bm);
        if (sb[0].enc_chk) begin
          chk("encoder_state", int'(best_state), sb[0].enc_s);
          chk("error_free_metric", int'(best_metric), 0);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int enc;
    logic [1:0] dd;
    model_reset();
    in_valid = 1'b0;
    frame_start = 1'b0;
    d_in = 2'b00;
    out_ready = 1'b1;
    rst = 1'b1;

    // Reset, then first symbol with frame_start: expect dec 00, best state 4, metric 0
    step(0, 0, 2'b00, 1, 1);
    step(0, 0, 2'b00, 1, 1);
    step(1, 1, 2'b11, 1, 0);
    step(0, 0, 2'b00, 1, 0);

    // Error-free encoded stream: best path is the encoder's own state at metric 0
    enc = 0;
    for (int i = 0; i < 16; i++) begin
      int b, r;
      b = int'($urandom_range(0, 1));
      r = b * 8 + enc;
      dd[1] = parity(r & G0I);
      dd[0] = parity(r & G1I);
      enc = b * 4 + enc / 2;
      enc_chk_now = 1'b1;
      enc_s_now = enc;
      step(1, (i == 0), dd, 1, 0);
    end
    enc_chk_now = 1'b0;

    // Backpressure: hold output stalled with a symbol waiting, then release
    for (int i = 0; i < 6; i++) step(1, 0, 2'(($urandom_range(0, 3))), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 2'(($urandom_range(0, 3))), 1, 0);

    // Random noise with random handshakes; MW=4 forces frequent normalisation
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
           2'(($urandom_range(0, 3))), ($urandom_range(0, 3) != 0), 0);
    end

    // Mid-stream frame restart on symbol 00: best state 0
    step(1, 1, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'(($urandom_range(0, 3))), 1, 0);

    // Reset while an output is pending, then the scenario-1 symbol without frame_start
    step(1, 0, 2'b01, 1, 0);
    step(1, 0, 2'b10, 0, 0);
    step(0, 0, 2'b00, 0, 1);
    step(1, 0, 2'b11, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 1, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("normalisation events in reference model: %0d", n_norm);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
